// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - mc_ctrl_pkg: FSM states, instruction classes, opcode/funct, ALU and mux select codes
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_ALU_WB = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WB = 4'd7,
        S_MEM_WR = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_J,
        CLS_JAL,
        CLS_JR,
        CLS_ILLEGAL
    } insn_cls_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;
    localparam logic [3:0] ALU_LUI  = 4'd3;

    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_JMP  = 2'd2;
    localparam logic [1:0] NPC_RS   = 2'd3;

    localparam logic [1:0] RDST_RT  = 2'd0;
    localparam logic [1:0] RDST_RD  = 2'd1;
    localparam logic [1:0] RDST_RA  = 2'd2;

    localparam logic [1:0] RSRC_ALU = 2'd0;
    localparam logic [1:0] RSRC_MEM = 2'd1;
    localparam logic [1:0] RSRC_PC4 = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller <-> datapath signal bundle (master = controller, slave = datapath)
interface multicycle_ctrl_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] npc_sel;
    logic [1:0] reg_dst;
    logic [1:0] reg_src;
    logic [3:0] alu_ctr;
    logic       alu_src;
    logic       imm_src;
    logic       illegal;
    logic [3:0] state_o;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, ir_write, reg_write, mem_read, mem_write,
               npc_sel, reg_dst, reg_src, alu_ctr, alu_src, imm_src, illegal, state_o
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, ir_write, reg_write, mem_read, mem_write,
               npc_sel, reg_dst, reg_src, alu_ctr, alu_src, imm_src, illegal, state_o
    );

endinterface

// File: rtl/multicycle_ctrl_decoder.sv
// rtl/multicycle_ctrl_decoder.sv - mc_decoder: combinational opcode/funct -> instruction class and ALU selects
module mc_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output insn_cls_t  cls,
    output logic [3:0] alu_ctr,
    output logic       alu_src,
    output logic       imm_src,
    output logic       illegal
);

    always_comb begin
        cls     = CLS_ILLEGAL;
        alu_ctr = ALU_ADD;
        alu_src = 1'b0;
        imm_src = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    // sll is only ever issued as nop, so it rides the addu path
                    FN_SLL, FN_ADDU: cls = CLS_ALU_R;
                    FN_SUBU: begin
                        cls     = CLS_ALU_R;
                        alu_ctr = ALU_SUB;
                    end
                    FN_JR:   cls = CLS_JR;
                    default: cls = CLS_ILLEGAL;
                endcase
            end
            OP_ORI: begin
                cls     = CLS_ALU_I;
                alu_ctr = ALU_OR;
                alu_src = 1'b1;
            end
            OP_LUI: begin
                cls     = CLS_ALU_I;
                alu_ctr = ALU_LUI;
                alu_src = 1'b1;
            end
            OP_LW, OP_SW: begin
                cls     = (opcode == OP_LW) ? CLS_LOAD : CLS_STORE;
                alu_ctr = ALU_ADD;
                alu_src = 1'b1;
                imm_src = 1'b1;
            end
            OP_BEQ: begin
                cls     = CLS_BRANCH;
                alu_ctr = ALU_SUB;
            end
            OP_J:    cls = CLS_J;
            OP_JAL:  cls = CLS_JAL;
            default: cls = CLS_ILLEGAL;
        endcase
    end

    assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS sequencer FSM; MC_PERF_CNT_EN adds cycle_cnt/instret_cnt counters
module multicycle_ctrl
    import mc_ctrl_pkg::*;
`ifdef MC_PERF_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instret_cnt
`endif
);

    state_t     state;
    state_t     state_nxt;
    insn_cls_t  cls;
    logic [3:0] dec_alu_ctr;
    logic       dec_alu_src;
    logic       dec_imm_src;
    logic       dec_illegal;

    mc_decoder u_dec (
        .opcode  (bus.opcode),
        .funct   (bus.funct),
        .cls     (cls),
        .alu_ctr (dec_alu_ctr),
        .alu_src (dec_alu_src),
        .imm_src (dec_imm_src),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (cls)
                    CLS_ALU_R, CLS_ALU_I: state_nxt = S_EXEC;
                    CLS_LOAD, CLS_STORE:  state_nxt = S_ADDR;
                    CLS_BRANCH:           state_nxt = S_BRANCH;
                    CLS_J, CLS_JAL, CLS_JR: state_nxt = S_JUMP;
                    default:              state_nxt = S_FETCH;
                endcase
            end
            S_EXEC:   state_nxt = S_ALU_WB;
            S_ALU_WB: state_nxt = S_FETCH;
            S_ADDR:   state_nxt = (cls == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: state_nxt = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB: state_nxt = S_FETCH;
            S_MEM_WR: state_nxt = bus.mem_ready ? S_FETCH : S_MEM_WR;
            S_BRANCH: state_nxt = S_FETCH;
            S_JUMP:   state_nxt = S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Strobes follow the state; reset forcing IDLE is what drops them asynchronously
    always_comb begin
        bus.pc_write  = 1'b0;
        bus.ir_write  = 1'b0;
        bus.reg_write = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.npc_sel   = NPC_PC4;
        bus.reg_dst   = RDST_RT;
        bus.reg_src   = RSRC_ALU;
        bus.alu_ctr   = ALU_ADD;
        bus.alu_src   = 1'b0;
        bus.imm_src   = 1'b0;
        bus.illegal   = 1'b0;
        case (state)
            S_FETCH:  bus.ir_write = 1'b1;
            S_DECODE: begin
                if (dec_illegal) begin
                    bus.illegal  = 1'b1;
                    bus.pc_write = 1'b1;
                end
            end
            S_EXEC: begin
                bus.alu_ctr = dec_alu_ctr;
                bus.alu_src = dec_alu_src;
                bus.imm_src = dec_imm_src;
            end
            S_ALU_WB: begin
                bus.alu_ctr   = dec_alu_ctr;
                bus.alu_src   = dec_alu_src;
                bus.imm_src   = dec_imm_src;
                bus.reg_write = 1'b1;
                bus.reg_dst   = (cls == CLS_ALU_R) ? RDST_RD : RDST_RT;
                bus.pc_write  = 1'b1;
            end
            S_ADDR, S_MEM_RD, S_MEM_WR: begin
                bus.alu_ctr   = ALU_ADD;
                bus.alu_src   = 1'b1;
                bus.imm_src   = 1'b1;
                bus.mem_read  = (state == S_MEM_RD);
                bus.mem_write = (state == S_MEM_WR);
                bus.pc_write  = (state == S_MEM_WR) && bus.mem_ready;
            end
            S_MEM_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_src   = RSRC_MEM;
                bus.pc_write  = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_ctr  = ALU_SUB;
                bus.pc_write = 1'b1;
                bus.npc_sel  = bus.zero ? NPC_BR : NPC_PC4;
            end
            S_JUMP: begin
                bus.pc_write = 1'b1;
                bus.npc_sel  = (cls == CLS_JR) ? NPC_RS : NPC_JMP;
                if (cls == CLS_JAL) begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = RDST_RA;
                    bus.reg_src   = RSRC_PC4;
                end
            end
            default: ;
        endcase
    end

    assign bus.state_o = state;

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != S_IDLE) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (bus.pc_write)    instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;
    import mc_ctrl_pkg::*;

    typedef struct {
        string name;
        int    op;
        int    fn;
        int    zero;
        int    wait_n;
        int    cyc;
        int    npc;
        int    rw;
        int    rdst;
        int    rsrc;
        int    mrd;
        int    mwr;
        int    ill;
        int    alu;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
    multicycle_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );
`else
    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`endif

    int   checks = 0;
    int   failures = 0;
    vec_t sb[$];
    vec_t vecs[16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read, bus.mem_write,
                     bus.npc_sel, bus.reg_dst, bus.reg_src, bus.alu_ctr, bus.alu_src,
                     bus.imm_src, bus.illegal});
    endfunction

    function automatic vec_t mk(input string n, input int op, input int fn, input int zero,
                                input int w, input int cyc, input int npc, input int rw,
                                input int rdst, input int rsrc, input int mrd, input int mwr,
                                input int ill, input int alu);
        vec_t v;
        v.name = n; v.op = op; v.fn = fn; v.zero = zero; v.wait_n = w; v.cyc = cyc;
        v.npc = npc; v.rw = rw; v.rdst = rdst; v.rsrc = rsrc; v.mrd = mrd; v.mwr = mwr;
        v.ill = ill; v.alu = alu;
        return v;
    endfunction

    // Entered just after the edge that puts the DUT in FETCH; returns likewise.
    task automatic run_insn(input vec_t v);
        vec_t e;
        int cyc = 0, n_rw = 0, n_mrd = 0, n_mwr = 0, n_ill = 0, n_ir = 0, both = 0;
        int rdst = 0, rsrc = 0, npc = -1, alu = 0;
        bit done = 1'b0;
`ifdef MC_PERF_CNT_EN
        int c0 = int'(cycle_cnt);
        int i0 = int'(instret_cnt);
`endif
        sb.push_back(v);
        bus.opcode = 6'(v.op);
        bus.funct  = 6'(v.fn);
        bus.zero   = (v.zero != 0);
        while (!done && cyc < 20) begin
            bus.mem_ready = (cyc >= 3 + v.wait_n);
            @(negedge clk);
            if (bus.reg_write) begin
                n_rw++;
                rdst = int'(bus.reg_dst);
                rsrc = int'(bus.reg_src);
            end
            if (bus.mem_read)  n_mrd++;
            if (bus.mem_write) n_mwr++;
            if (bus.illegal)   n_ill++;
            if (bus.ir_write)  n_ir++;
            if (bus.mem_read && bus.mem_write) both++;
            if (cyc == 2) alu = int'(bus.alu_ctr);
            if (bus.pc_write) begin
                done = 1'b1;
                npc  = int'(bus.npc_sel);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        e = sb.pop_front();
        chk({e.name, "_retired"}, int'(done), 1);
        chk({e.name, "_cycles"}, cyc, e.cyc);
        chk({e.name, "_npc_sel"}, npc, e.npc);
        chk({e.name, "_reg_write_cnt"}, n_rw, e.rw);
        chk({e.name, "_reg_dst"}, rdst, e.rdst);
        chk({e.name, "_reg_src"}, rsrc, e.rsrc);
        chk({e.name, "_mem_read_cnt"}, n_mrd, e.mrd);
        chk({e.name, "_mem_write_cnt"}, n_mwr, e.mwr);
        chk({e.name, "_illegal_cnt"}, n_ill, e.ill);
        chk({e.name, "_alu_ctr"}, alu, e.alu);
        chk({e.name, "_ir_write_cnt"}, n_ir, 1);
        chk({e.name, "_rd_wr_overlap"}, both, 0);
`ifdef MC_PERF_CNT_EN
        chk({e.name, "_cycle_cnt_delta"}, int'(cycle_cnt) - c0, e.cyc);
        chk({e.name, "_instret_delta"}, int'(instret_cnt) - i0, 1);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pw;
        //          name     op       fn       z  w  cyc npc rw dst src mrd mwr ill alu
        vecs[0]  = mk("ori",   OP_ORI,  0,       0, 0, 4, 0, 1, 0, 0, 0, 0, 0, ALU_OR);
        vecs[1]  = mk("addu",  0,       FN_ADDU, 0, 0, 4, 0, 1, 1, 0, 0, 0, 0, ALU_ADD);
        vecs[2]  = mk("subu",  0,       FN_SUBU, 1, 0, 4, 0, 1, 1, 0, 0, 0, 0, ALU_SUB);
        vecs[3]  = mk("lui",   OP_LUI,  0,       0, 0, 4, 0, 1, 0, 0, 0, 0, 0, ALU_LUI);
        vecs[4]  = mk("nop",   0,       FN_SLL,  0, 0, 4, 0, 1, 1, 0, 0, 0, 0, ALU_ADD);
        vecs[5]  = mk("lw0",   OP_LW,   0,       0, 0, 5, 0, 1, 0, 1, 1, 0, 0, ALU_ADD);
        vecs[6]  = mk("lw2",   OP_LW,   0,       0, 2, 7, 0, 1, 0, 1, 3, 0, 0, ALU_ADD);
        vecs[7]  = mk("sw0",   OP_SW,   0,       0, 0, 4, 0, 0, 0, 0, 0, 1, 0, ALU_ADD);
        vecs[8]  = mk("sw1",   OP_SW,   0,       0, 1, 5, 0, 0, 0, 0, 0, 2, 0, ALU_ADD);
        vecs[9]  = mk("beq_t", OP_BEQ,  0,       1, 0, 3, 1, 0, 0, 0, 0, 0, 0, ALU_SUB);
        vecs[10] = mk("beq_n", OP_BEQ,  0,       0, 0, 3, 0, 0, 0, 0, 0, 0, 0, ALU_SUB);
        vecs[11] = mk("j",     OP_J,    0,       0, 0, 3, 2, 0, 0, 0, 0, 0, 0, ALU_ADD);
        vecs[12] = mk("jal",   OP_JAL,  0,       0, 0, 3, 2, 1, 2, 2, 0, 0, 0, ALU_ADD);
        vecs[13] = mk("jr",    0,       FN_JR,   0, 0, 3, 3, 0, 0, 0, 0, 0, 0, ALU_ADD);
        vecs[14] = mk("ill_op", 'h3f,   0,       0, 0, 2, 0, 0, 0, 0, 0, 0, 1, ALU_ADD);
        vecs[15] = mk("ill_fn", 0,      'h3f,    0, 0, 2, 0, 0, 0, 0, 0, 0, 1, ALU_ADD);

        reset = 1'b0;
        bus.opcode = 6'h3f; bus.funct = 6'h3f; bus.zero = 1'b1; bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_outputs", outs(), 0);
            chk("rst_state", int'(bus.state_o), S_IDLE);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("idle_state", int'(bus.state_o), S_IDLE);
        chk("idle_outputs", outs(), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fetch_state", int'(bus.state_o), S_FETCH);
        chk("fetch_ir_write", int'(bus.ir_write), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("decode_state", int'(bus.state_o), S_DECODE);
        chk("decode_illegal", int'(bus.illegal), 1);
        chk("decode_pc_write", int'(bus.pc_write), 1);
        @(posedge clk); #1;
`ifdef MC_PERF_CNT_EN
        chk("boot_instret", int'(instret_cnt), 1);
        chk("boot_cycles", int'(cycle_cnt), 2);
`endif

        for (int i = 0; i < 16; i++) run_insn(vecs[i]);

        // sw stuck waiting on memory, then reset pulled mid-wait
        bus.opcode = OP_SW; bus.funct = 6'h00; bus.mem_ready = 1'b0; pw = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.pc_write) pw++;
            if (c < 4) begin
                @(posedge clk); #1;
            end
        end
        chk("sw_wait_state", int'(bus.state_o), S_MEM_WR);
        chk("sw_wait_mem_write", int'(bus.mem_write), 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_mem_write", int'(bus.mem_write), 0);
        chk("rst_async_state", int'(bus.state_o), S_IDLE);
        chk("rst_async_pc_write", int'(bus.pc_write), 0);
        chk("sw_wait_no_pc_write", pw, 0);
`ifdef MC_PERF_CNT_EN
        chk("rst_cycle_cnt_clear", int'(cycle_cnt), 0);
        chk("rst_instret_clear", int'(instret_cnt), 0);
`endif
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("rerst_idle_state", int'(bus.state_o), S_IDLE);
        @(posedge clk); #1;
        run_insn(vecs[1]);
        run_insn(vecs[6]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
